// File: rtl/mixcolumns_serial_ctrl_pkg.sv
// Shared widths, column count and FSM encoding for the serial MixColumns stage.
package mixcolumns_serial_ctrl_pkg;

   localparam int BYTE     = 8;
   localparam int WORD     = 4 * BYTE;
   localparam int SENTENCE = 4 * WORD;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MIX  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mixcolumns_serial_ctrl_if.sv
// Handshake bundle between ShiftRows (upstream), this stage and AddRoundKey (downstream).
interface mixcolumns_serial_ctrl_if;
   import mixcolumns_serial_ctrl_pkg::*;

   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [SENTENCE-1:0] in_data;
   logic                in_bypass;
   logic                out_valid;
   logic                out_ready;
   logic [SENTENCE-1:0] out_data;
   logic                busy;

   modport master (
      output flush, in_valid, in_data, in_bypass, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  flush, in_valid, in_data, in_bypass, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/mixcolumns_serial_ctrl_set_columns.sv
// Single-column MixColumns: circulant {2,3,1,1} over GF(2^8), row 0 in the MSB byte.
module Set_Columns
   import mixcolumns_serial_ctrl_pkg::*;
(
   input  logic [WORD-1:0] i_col,
   output logic [WORD-1:0] o_col
);

   function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
      return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? 8'h1b : 8'h00);
   endfunction

   logic [BYTE-1:0] w_a0, w_a1, w_a2, w_a3;

   assign w_a0 = i_col[31:24];
   assign w_a1 = i_col[23:16];
   assign w_a2 = i_col[15:8];
   assign w_a3 = i_col[7:0];

   // Each output row is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
   always_comb begin
      o_col[31:24] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      o_col[23:16] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      o_col[15:8]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      o_col[7:0]   = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
   end

endmodule

// File: rtl/mixcolumns_serial_ctrl.sv
// Area-reduced MixColumns: one shared column mixer walks the four words of the
// state in place, one column per clock. Bypass skips mixing for the last round.
//
// state | meaning
// IDLE  | ready for a new state; in_ready high
// MIX   | column col_cnt is mixed and written back each cycle
// DONE  | result presented with out_valid until out_ready
module mixcolumns_serial_ctrl
   import mixcolumns_serial_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   mixcolumns_serial_ctrl_if.slave  bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_col_cnt;
   logic [1:0]          w_col_cnt_nxt;
   logic [SENTENCE-1:0] r_data;
   logic [SENTENCE-1:0] w_data_nxt;
   logic [WORD-1:0]     w_col_in;
   logic [WORD-1:0]     w_col_out;

   // Word select feeding the shared mixer
   always_comb begin
      w_col_in = r_data[{r_col_cnt, 5'd0} +: WORD];
   end

   Set_Columns u_set_columns (
      .i_col (w_col_in),
      .o_col (w_col_out)
   );

   // Outputs come only from registers, so there is no in_* to out_* path
   always_comb begin
      bus.in_ready  = (r_state == IDLE);
      bus.out_valid = (r_state == DONE);
      bus.busy      = (r_state != IDLE);
      bus.out_data  = r_data;
   end

   // Next state, column counter and in-place write-back; flush overrides all
   always_comb begin
      w_state_nxt   = r_state;
      w_col_cnt_nxt = r_col_cnt;
      w_data_nxt    = r_data;
      if (bus.flush) begin
         w_state_nxt   = IDLE;
         w_col_cnt_nxt = 2'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  w_data_nxt    = bus.in_data;
                  w_col_cnt_nxt = 2'd0;
                  w_state_nxt   = bus.in_bypass ? DONE : MIX;
               end
            end
            MIX: begin
               w_data_nxt[{r_col_cnt, 5'd0} +: WORD] = w_col_out;
               w_col_cnt_nxt = r_col_cnt + 2'd1;
               if (r_col_cnt == 2'(NUM_COLS - 1)) begin
                  w_state_nxt = DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt   = IDLE;
               w_col_cnt_nxt = 2'd0;
            end
         endcase
      end
   end

   // State, counter and data registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_col_cnt <= 2'd0;
         r_data    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_col_cnt <= w_col_cnt_nxt;
         r_data    <= w_data_nxt;
      end
   end

endmodule

// File: tb/tb_mixcolumns_serial_ctrl.sv
// Directed and random checks for the serial MixColumns stage against a GF(2^8) model.
module tb_mixcolumns_serial_ctrl;
   import mixcolumns_serial_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mixcolumns_serial_ctrl_if bus_if ();

   mixcolumns_serial_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] model_col(input logic [31:0] w);
      logic [7:0] a [4];
      logic [7:0] o [4];
      logic [7:0] coef [4];
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      for (int r = 0; r < 4; r++) a[r] = w[31-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
         o[r] = 8'h00;
         for (int c = 0; c < 4; c++) o[r] = o[r] ^ gmul(a[c], coef[(c - r) & 3]);
      end
      return {o[0], o[1], o[2], o[3]};
   endfunction

   function automatic logic [127:0] model_state(input logic [127:0] s, input logic byp);
      logic [127:0] r = s;
      if (!byp) for (int k = 0; k < 4; k++) r[32*k +: 32] = model_col(s[32*k +: 32]);
      return r;
   endfunction

   // Present one state at a negedge; returns just after the accept edge.
   task automatic accept(input logic [127:0] d, input logic byp);
      int n = 0;
      @(negedge clk);
      while (!bus_if.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", bus_if.in_ready, 1'b1);
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = d;
      bus_if.in_bypass = byp;
      @(posedge clk);
      #1;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus_if.in_bypass = 1'($urandom);
   endtask

   // Counts clock edges after the accept edge until out_valid; busy must hold meanwhile.
   task automatic wait_out(output int edges);
      edges = 0;
      while (!bus_if.out_valid && edges < 50) begin
         chk("busy_while_mixing", bus_if.busy, 1'b1);
         @(posedge clk);
         #1;
         edges++;
      end
      if (edges >= 50) chk("out_valid_timeout", 1'b0, 1'b1);
   endtask

   // Check result, take it, and confirm out_valid was a one-cycle pulse.
   task automatic take(input string tag, input logic [127:0] exp);
      chk(tag, bus_if.out_data, exp);
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, bus_if.out_valid, 1'b0);
      chk({tag, "_ready_back"}, bus_if.in_ready, 1'b1);
   endtask

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "simulation timed out");
   end

   initial begin : stim
      logic [127:0] d, e, hold;
      int lat;

      bus_if.flush     = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.in_bypass = 1'b0;
      bus_if.out_ready = 1'b1;
      #1;
      chk("rst_in_ready", bus_if.in_ready, 1'b1);
      chk("rst_out_valid", bus_if.out_valid, 1'b0);
      chk("rst_out_data", bus_if.out_data, 128'h0);
      chk("rst_busy", bus_if.busy, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Known-answer column repeated in all four words
      accept({4{32'hdb135345}}, 1'b0);
      wait_out(lat);
      chk("mix_latency", 32'(lat), 32'd4);
      take("kat_db135345", {4{32'h8e4da1bc}});

      // Four distinct columns
      d = {32'h2d26314c, 32'hd4d4d4d5, 32'hc6c6c6c6, 32'hf20a225c};
      accept(d, 1'b0);
      wait_out(lat);
      chk("mix_latency2", 32'(lat), 32'd4);
      take("kat_mixed", {32'h4d7ebdf8, 32'hd5d5d7d6, 32'hc6c6c6c6, 32'h9fdc589d});

      // Bypass: out_valid in the cycle right after the accept edge
      d = 128'h00112233445566778899aabbccddeeff;
      accept(d, 1'b1);
      wait_out(lat);
      chk("bypass_latency", 32'(lat), 32'd0);
      take("bypass_data", d);

      // Backpressure in DONE with upstream noise
      bus_if.out_ready = 1'b0;
      accept({4{32'hdb135345}}, 1'b0);
      wait_out(lat);
      hold = {4{32'h8e4da1bc}};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus_if.in_valid = 1'(i & 1);
         bus_if.in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         #1;
         chk("bp_out_data", bus_if.out_data, hold);
         chk("bp_in_ready", bus_if.in_ready, 1'b0);
         chk("bp_out_valid", bus_if.out_valid, 1'b1);
      end
      @(negedge clk);
      d = 128'hfedcba98765432100123456789abcdef;
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = d;
      bus_if.in_bypass = 1'b1;
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hs_no_reaccept", bus_if.busy, 1'b0);
      chk("bp_hs_out_valid", bus_if.out_valid, 1'b0);
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b0;
      chk("bp_next_accept", bus_if.out_valid, 1'b1);
      take("bp_next_data", d);

      // Flush with col_cnt = 2
      accept({4{32'h01020304}}, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      bus_if.flush    = 1'b1;
      bus_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.flush    = 1'b0;
      bus_if.in_valid = 1'b0;
      chk("flush_busy", bus_if.busy, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("flush_no_valid", bus_if.out_valid, 1'b0);
      end
      // Flush in IDLE beats in_valid
      @(negedge clk);
      bus_if.flush    = 1'b1;
      bus_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.flush    = 1'b0;
      bus_if.in_valid = 1'b0;
      chk("flush_idle_no_accept", bus_if.busy, 1'b0);
      d = {32'h2d26314c, 32'hd4d4d4d5, 32'hc6c6c6c6, 32'hf20a225c};
      accept(d, 1'b0);
      wait_out(lat);
      take("after_flush", model_state(d, 1'b0));
      // Flush in DONE
      bus_if.out_ready = 1'b0;
      accept(d, 1'b1);
      wait_out(lat);
      bus_if.flush = 1'b1;
      @(posedge clk);
      #1;
      bus_if.flush = 1'b0;
      chk("flush_done_valid", bus_if.out_valid, 1'b0);
      bus_if.out_ready = 1'b1;

      // Asynchronous reset mid-MIX
      accept({4{32'hdb135345}}, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_mix_in_ready", bus_if.in_ready, 1'b1);
      chk("arst_mix_out_valid", bus_if.out_valid, 1'b0);
      chk("arst_mix_out_data", bus_if.out_data, 128'h0);
      chk("arst_mix_busy", bus_if.busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      // Asynchronous reset mid-DONE
      bus_if.out_ready = 1'b0;
      accept(128'h0f0e0d0c0b0a09080706050403020100, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_done_out_valid", bus_if.out_valid, 1'b0);
      chk("arst_done_out_data", bus_if.out_data, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      d = 128'h00112233445566778899aabbccddeeff;
      accept(d, 1'b0);
      wait_out(lat);
      take("after_arst", model_state(d, 1'b0));

      // Random regression with stalls
      for (int n = 0; n < 1000; n++) begin
         logic b;
         d = {$urandom, $urandom, $urandom, $urandom};
         b = 1'($urandom_range(0, 1));
         e = model_state(d, b);
         bus_if.out_ready = 1'b0;
         accept(d, b);
         wait_out(lat);
         chk("rnd_latency", 32'(lat), b ? 32'd0 : 32'd4);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         chk("rnd_valid", bus_if.out_valid, 1'b1);
         take("rnd_data", e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
